// File: rtl/alu_sequencer_pkg.sv
// Shared ALU definitions: command encodings used by both the ALU and the
// sequencer, the sequencer state type, and response FIFO sizing.
package alu_sequencer_pkg;

    // ALU command encodings; the ALU decodes exactly these values.
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } seq_state_e;

    localparam int          FIFO_DEPTH   = 2;
    localparam logic [1:0]  FIFO_FULL    = 2'd2;
    localparam logic [15:0] OP_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Two-entry response FIFO with show-ahead output.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   push, push_data     - write one entry (ignored when full and not popping)
//   pop                 - drop the oldest entry (ignored when empty)
//   pop_data            - oldest entry, valid whenever count != 0
//   count               - number of stored entries (0..2)
module alu_rsp_fifo
    import alu_sequencer_pkg::*;
#(
    parameter int width = 35
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] pop_data,
    output logic [1:0]       count
);

    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic [width-1:0] mem_reg [FIFO_DEPTH];
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees a slot, so a full FIFO may still take a push.
    always_comb begin
        do_pop  = pop && (count_reg != 2'd0);
        do_push = push && ((count_reg != FIFO_FULL) || do_pop);
    end

    // Entries are reset to zero so the response data reads as zero after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // One-bit pointers wrap modulo 2 by construction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 2'd1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 2'd1;
            end
        end
    end

    assign pop_data = mem_reg[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer that feeds an external combinational ALU one operation at a time
// and buffers results in a two-entry response FIFO.
// Ports:
//   clk, reset_n                       - clock, asynchronous active-low reset
//   req_valid/req_ready                - request handshake
//   req_cmd, req_a, req_b              - ALU command and operands
//   alu_operandA/B, alu_command        - registered drive to the ALU
//   alu_result, alu_carryout/zero/overflow - ALU outputs, sampled in EXEC
//   rsp_valid/rsp_ready                - response handshake
//   rsp_result, rsp_carryout/zero/overflow - oldest buffered response
//   op_count                           - completed operations, saturating
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [width-1:0] req_a,
    input  logic [width-1:0] req_b,
    output logic [width-1:0] alu_operandA,
    output logic [width-1:0] alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [width-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [width-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic [15:0]      op_count
);

    seq_state_e       state_reg;
    seq_state_e       state_next;
    alu_cmd_e         cmd_reg;
    logic [width-1:0] a_reg;
    logic [width-1:0] b_reg;
    logic [15:0]      op_count_reg;
    logic             accept;
    logic             push;
    logic             pop;
    logic [1:0]       fifo_count;
    logic [width+2:0] fifo_wdata;
    logic [width+2:0] fifo_rdata;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        push       = 1'b0;
        // New work only while idle and the FIFO can absorb the result.
        req_ready  = (state_reg == ST_IDLE) && (fifo_count != FIFO_FULL);
        case (state_reg)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The ALU has had a full cycle on the registered operands.
                push       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cmd_reg   <= ALU_ADD;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cmd_reg <= alu_cmd_e'(req_cmd);
                a_reg   <= req_a;
                b_reg   <= req_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_count_reg <= 16'd0;
        end else if (push && (op_count_reg != OP_COUNT_MAX)) begin
            op_count_reg <= op_count_reg + 16'd1;
        end
    end

    assign alu_operandA = a_reg;
    assign alu_operandB = b_reg;
    assign alu_command  = cmd_reg;
    assign op_count     = op_count_reg;

    assign fifo_wdata = {alu_carryout, alu_zero, alu_overflow, alu_result};
    assign pop        = rsp_valid && rsp_ready;

    alu_rsp_fifo #(
        .width(width + 3)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_data(fifo_wdata),
        .pop      (pop),
        .pop_data (fifo_rdata),
        .count    (fifo_count)
    );

    assign rsp_valid    = (fifo_count != 2'd0);
    assign rsp_carryout = fifo_rdata[width+2];
    assign rsp_zero     = fifo_rdata[width+1];
    assign rsp_overflow = fifo_rdata[width];
    assign rsp_result   = fifo_rdata[width-1:0];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a 32-bit ALU model, directed vector table,
// hand-written backpressure / reset / saturation sequences and a randomized
// phase checked against a transaction-level reference model.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [2:0]  alu_command;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_zero;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carryout;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic [15:0] op_count;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_sequencer #(.width(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_operandA(alu_operandA),
        .alu_operandB(alu_operandB),
        .alu_command (alu_command),
        .alu_result  (alu_result),
        .alu_carryout(alu_carryout),
        .alu_zero    (alu_zero),
        .alu_overflow(alu_overflow),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_carryout(rsp_carryout),
        .rsp_zero    (rsp_zero),
        .rsp_overflow(rsp_overflow),
        .op_count    (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Combinational 32-bit ALU.
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum      = '0;
        alu_result   = '0;
        alu_carryout = 1'b0;
        alu_overflow = 1'b0;
        case (alu_cmd_e'(alu_command))
            ALU_ADD: begin
                alu_sum      = {1'b0, alu_operandA} + {1'b0, alu_operandB};
                alu_result   = alu_sum[31:0];
                alu_carryout = alu_sum[32];
                alu_overflow = (alu_operandA[31] == alu_operandB[31]) &&
                               (alu_result[31] != alu_operandA[31]);
            end
            ALU_SUB: begin
                alu_sum      = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
                alu_result   = alu_sum[31:0];
                alu_carryout = alu_sum[32];
                alu_overflow = (alu_operandA[31] != alu_operandB[31]) &&
                               (alu_result[31] != alu_operandA[31]);
            end
            ALU_XOR:  alu_result = alu_operandA ^ alu_operandB;
            ALU_SLT:  alu_result = {31'd0, $signed(alu_operandA) < $signed(alu_operandB)};
            ALU_AND:  alu_result = alu_operandA & alu_operandB;
            ALU_NAND: alu_result = ~(alu_operandA & alu_operandB);
            ALU_NOR:  alu_result = ~(alu_operandA | alu_operandB);
            ALU_OR:   alu_result = alu_operandA | alu_operandB;
            default:  alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct packed {
        logic        c;
        logic        z;
        logic        o;
        logic [31:0] res;
    } rsp_t;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        o;
    } vec_t;

    localparam longint S_MAX = 64'sh7FFFFFFF;
    localparam longint S_MIN = -64'sh80000000;

    // Reference result from plain integer arithmetic.
    function automatic rsp_t ref_op(input logic [2:0] cmd, input logic [31:0] a,
                                    input logic [31:0] b);
        rsp_t           r;
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        r = '0;
        case (cmd)
            3'd0: begin
                r.res = a + b;
                r.c   = (ua + ub) > 64'hFFFF_FFFF;
                r.o   = ((sa + sb) > S_MAX) || ((sa + sb) < S_MIN);
            end
            3'd1: begin
                r.res = a - b;
                r.c   = (ua >= ub);
                r.o   = ((sa - sb) > S_MAX) || ((sa - sb) < S_MIN);
            end
            3'd2: r.res = a ^ b;
            3'd3: r.res = (sa < sb) ? 32'd1 : 32'd0;
            3'd4: r.res = a & b;
            3'd5: r.res = ~(a & b);
            3'd6: r.res = ~(a | b);
            default: r.res = a | b;
        endcase
        r.z = (r.res == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One operation with rsp_ready high; checks latency, data and op_count.
    task automatic run_op(input string tag, input logic [2:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input rsp_t exp, input logic [15:0] exp_cnt);
        int waited = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_a     = a;
        req_b     = b;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_req_ready_timeout: req_ready stayed 0 for 20 cycles", tag);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_valid_early"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_rsp"}, 64'({rsp_carryout, rsp_zero, rsp_overflow, rsp_result}), 64'(exp));
        check({tag, "_op_count"}, 64'(op_count), 64'(exp_cnt));
        $display("[TB] %s cmd=%0d a=0x%08h b=0x%08h -> result=0x%08h c=%0b z=%0b o=%0b count=%0d",
                 tag, cmd, a, b, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, op_count);
    endtask

    vec_t vecs[13];

    initial begin
        rsp_t r1, r2, r3;
        rsp_t vis_q[$];
        rsp_t inflight_rec;
        logic inflight;
        int   completed;

        vecs[0]  = '{ALU_ADD,  32'd5,          32'd3,          32'd8,          1'b0, 1'b0, 1'b0};
        vecs[1]  = '{ALU_SUB,  32'h0000_1234,  32'h0000_1234,  32'h0000_0000,  1'b1, 1'b1, 1'b0};
        vecs[2]  = '{ALU_ADD,  32'h7FFF_FFFF,  32'h0000_0001,  32'h8000_0000,  1'b0, 1'b0, 1'b1};
        vecs[3]  = '{ALU_SLT,  32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0001,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{ALU_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0, 1'b0, 1'b0};
        vecs[5]  = '{ALU_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{ALU_NAND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FFF_0FFF,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{ALU_NOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h000F_000F,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{ALU_OR,   32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{ALU_ADD,  32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0000,  1'b1, 1'b1, 1'b0};
        vecs[10] = '{ALU_SUB,  32'h8000_0000,  32'h0000_0001,  32'h7FFF_FFFF,  1'b1, 1'b0, 1'b1};
        vecs[11] = '{ALU_SLT,  32'h0000_0001,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0, 1'b1, 1'b0};
        vecs[12] = '{ALU_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_cmd   = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset state.
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_operands", 64'({alu_command, alu_operandA}), 64'd0);
        check("rst_operand_b", 64'(alu_operandB), 64'd0);
        check("rst_rsp_data", 64'({rsp_carryout, rsp_zero, rsp_overflow, rsp_result}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // Directed vectors.
        for (int i = 0; i < 13; i++) begin
            rsp_t e;
            e.res = vecs[i].res;
            e.c   = vecs[i].c;
            e.z   = vecs[i].z;
            e.o   = vecs[i].o;
            run_op($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].a, vecs[i].b, e, 16'(i + 1));
        end

        // Backpressure, FIFO full, in-order drain, simultaneous push/pop.
        do_reset();
        r1 = ref_op(3'd0, 32'd10, 32'd20);
        r2 = ref_op(3'd1, 32'd100, 32'd1);
        r3 = ref_op(3'd2, 32'hAAAA_0000, 32'h0000_5555);
        req_valid = 1'b1; req_cmd = 3'd0; req_a = 32'd10; req_b = 32'd20;
        @(negedge clk);
        check("bp_exec_not_ready", 64'(req_ready), 64'd0);
        req_cmd = 3'd1; req_a = 32'd100; req_b = 32'd1;
        @(negedge clk);
        check("bp_first_rsp", 64'({rsp_valid, rsp_carryout, rsp_zero, rsp_overflow, rsp_result}),
              64'({1'b1, r1}));
        check("bp_ready_count1", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_cmd = 3'd2; req_a = 32'hAAAA_0000; req_b = 32'h0000_5555;
        @(negedge clk);
        check("bp_full_not_ready", 64'(req_ready), 64'd0);
        check("bp_full_head", 64'({rsp_carryout, rsp_zero, rsp_overflow, rsp_result}), 64'(r1));
        @(negedge clk);
        check("bp_full_still_not_ready", 64'(req_ready), 64'd0);
        check("bp_op_count2", 64'(op_count), 64'd2);
        check("bp_head_stable", 64'({rsp_carryout, rsp_zero, rsp_overflow, rsp_result}), 64'(r1));
        check("bp_ignored_req", 64'(alu_operandA), 64'd100);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_second_rsp", 64'({rsp_carryout, rsp_zero, rsp_overflow, rsp_result}), 64'(r2));
        check("bp_ready_after_pop", 64'(req_ready), 64'd1);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_third_accepted", 64'(alu_operandA), 64'hAAAA_0000);
        check("bp_hold_second", 64'({rsp_valid, rsp_carryout, rsp_zero, rsp_overflow, rsp_result}),
              64'({1'b1, r2}));
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_pushpop_third", 64'({rsp_valid, rsp_carryout, rsp_zero, rsp_overflow, rsp_result}),
              64'({1'b1, r3}));
        check("bp_op_count3", 64'(op_count), 64'd3);
        @(negedge clk);
        check("bp_drained", 64'(rsp_valid), 64'd0);
        $display("[TB] backpressure sequence done, op_count=%0d", op_count);

        // Reset while an operation is in EXEC.
        do_reset();
        req_valid = 1'b1; req_cmd = 3'd0; req_a = 32'd1; req_b = 32'd2;
        @(negedge clk);
        req_cmd = 3'd0; req_a = 32'd7; req_b = 32'd8;
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rx_pre_exec", 64'({req_ready, rsp_valid}), 64'b01);
        check("rx_pre_count", 64'(op_count), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rx_async_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rx_async_op_count", 64'(op_count), 64'd0);
        check("rx_async_operand", 64'(alu_operandA), 64'd0);
        check("rx_async_rsp_data", 64'(rsp_result), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rx_no_stale", 64'({rsp_valid, op_count}), 64'd0);
            check("rx_ready", 64'(req_ready), 64'd1);
        end
        $display("[TB] reset-in-EXEC sequence done");

        // op_count saturation: preload near the top, then complete real operations.
        do_reset();
        force dut.op_count_reg = 16'hFFFD;
        @(negedge clk);
        release dut.op_count_reg;
        @(negedge clk);
        check("sat_preload", 64'(op_count), 64'hFFFD);
        run_op("sat0", 3'd0, 32'd1, 32'd1, ref_op(3'd0, 32'd1, 32'd1), 16'hFFFE);
        run_op("sat1", 3'd0, 32'd2, 32'd2, ref_op(3'd0, 32'd2, 32'd2), 16'hFFFF);
        run_op("sat2", 3'd4, 32'd3, 32'd6, ref_op(3'd4, 32'd3, 32'd6), 16'hFFFF);
        run_op("sat3", 3'd7, 32'd3, 32'd6, ref_op(3'd7, 32'd3, 32'd6), 16'hFFFF);

        // Randomized traffic against a transaction-level model.
        do_reset();
        inflight  = 1'b0;
        completed = 0;
        vis_q.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic model_ready;
            logic acc;
            logic pop;
            @(negedge clk);
            model_ready = !inflight && (vis_q.size() < 2);
            check("rnd_req_ready", 64'(req_ready), 64'(model_ready));
            check("rnd_rsp_valid", 64'(rsp_valid), 64'(vis_q.size() != 0));
            if (vis_q.size() != 0) begin
                check("rnd_rsp", 64'({rsp_carryout, rsp_zero, rsp_overflow, rsp_result}),
                      64'(vis_q[0]));
            end
            check("rnd_op_count", 64'(op_count), 64'((completed > 65535) ? 65535 : completed));

            req_valid = ($urandom_range(0, 3) != 0);
            req_cmd   = 3'($urandom_range(0, 7));
            req_a     = pick_operand();
            req_b     = pick_operand();
            rsp_ready = ($urandom_range(0, 2) != 0);

            acc = req_valid && model_ready;
            pop = (vis_q.size() != 0) && rsp_ready;
            if (pop) begin
                $display("[TB] rnd pop: result=0x%08h c=%0b z=%0b o=%0b", vis_q[0].res,
                         vis_q[0].c, vis_q[0].z, vis_q[0].o);
                void'(vis_q.pop_front());
            end
            if (inflight) begin
                vis_q.push_back(inflight_rec);
                completed++;
                inflight = 1'b0;
            end
            if (acc) begin
                inflight     = 1'b1;
                inflight_rec = ref_op(req_cmd, req_a, req_b);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
